// File: rtl/fu_jump_pipe_if.sv
// Issue/result bundle for the jump/branch functional unit.
// Prediction signals exist only when JUMP_PREDICT_EN is defined.
interface fu_jump_pipe_if #(
  parameter int XLEN = 32
);
  logic            EN;
  logic            flush;
  logic            JAL;
  logic            JALR;
  logic [2:0]      cmp_ctrl;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] PC;
  logic [XLEN-1:0] PC_jump;
  logic [XLEN-1:0] PC_wb;
  logic            cmp_res;
  logic            finish;
  logic            busy;
`ifdef JUMP_PREDICT_EN
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            mispredict;

  modport master (
    output EN, flush, JAL, JALR, cmp_ctrl, rs1_data, rs2_data, imm, PC,
           pred_taken, pred_target,
    input  PC_jump, PC_wb, cmp_res, finish, busy, mispredict
  );
  modport slave (
    input  EN, flush, JAL, JALR, cmp_ctrl, rs1_data, rs2_data, imm, PC,
           pred_taken, pred_target,
    output PC_jump, PC_wb, cmp_res, finish, busy, mispredict
  );
`else
  modport master (
    output EN, flush, JAL, JALR, cmp_ctrl, rs1_data, rs2_data, imm, PC,
    input  PC_jump, PC_wb, cmp_res, finish, busy
  );
  modport slave (
    input  EN, flush, JAL, JALR, cmp_ctrl, rs1_data, rs2_data, imm, PC,
    output PC_jump, PC_wb, cmp_res, finish, busy
  );
`endif
endinterface

// File: rtl/fu_jump_pipe.sv
// Jump/branch functional unit with LAT-cycle issue-to-finish latency.
// Optional branch-prediction check enabled by macro JUMP_PREDICT_EN.
//
// state   | meaning
// IDLE    | no operation in flight
// RUN     | operation in flight, latency timer counting down
// DONE    | results valid, finish pulse, may accept the next issue
module fu_jump_pipe #(
  parameter int XLEN = 32,
  parameter int LAT  = 1
) (
  input logic          clk,
  input logic          rst_n,
  fu_jump_pipe_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  localparam logic [2:0] CNT_LOAD = 3'(LAT - 1);

  state_t          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            valid_q, valid_d;
  logic            jal_q, jal_d, jalr_q, jalr_d;
  logic [2:0]      ctrl_q, ctrl_d;
  logic [XLEN-1:0] rs1_q, rs1_d, rs2_q, rs2_d, imm_q, imm_d, pc_q, pc_d;
  logic            accept;
  logic            cond;
  logic            taken;
  logic [XLEN-1:0] target;
`ifdef JUMP_PREDICT_EN
  logic            pt_q, pt_d;
  logic [XLEN-1:0] ptgt_q, ptgt_d;
`endif

  assign accept = bus.EN && !bus.flush && (state_q == ST_IDLE || state_q == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      jal_q   <= 1'b0;
      jalr_q  <= 1'b0;
      ctrl_q  <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      imm_q   <= '0;
      pc_q    <= '0;
`ifdef JUMP_PREDICT_EN
      pt_q    <= 1'b0;
      ptgt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      jal_q   <= jal_d;
      jalr_q  <= jalr_d;
      ctrl_q  <= ctrl_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      imm_q   <= imm_d;
      pc_q    <= pc_d;
`ifdef JUMP_PREDICT_EN
      pt_q    <= pt_d;
      ptgt_q  <= ptgt_d;
`endif
    end
  end

  // Flush wins over a same-edge issue; the timer hits DONE on terminal count 1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (bus.flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (accept) begin
      if (LAT == 1) begin
        state_d = ST_DONE;
        cnt_d   = '0;
      end else begin
        state_d = ST_RUN;
        cnt_d   = CNT_LOAD;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          cnt_d = 3'(cnt_q - 3'd1);
          if (cnt_q <= 3'd1) state_d = ST_DONE;
        end
        ST_DONE: state_d = ST_IDLE;
        default: ;
      endcase
    end
  end

  always_comb begin
    valid_d = valid_q | accept;
    jal_d   = accept ? bus.JAL      : jal_q;
    jalr_d  = accept ? bus.JALR     : jalr_q;
    ctrl_d  = accept ? bus.cmp_ctrl : ctrl_q;
    rs1_d   = accept ? bus.rs1_data : rs1_q;
    rs2_d   = accept ? bus.rs2_data : rs2_q;
    imm_d   = accept ? bus.imm      : imm_q;
    pc_d    = accept ? bus.PC       : pc_q;
`ifdef JUMP_PREDICT_EN
    pt_d    = accept ? bus.pred_taken  : pt_q;
    ptgt_d  = accept ? bus.pred_target : ptgt_q;
`endif
  end

  // Results derive from captured operands; valid_q keeps them at zero until the first issue.
  always_comb begin
    cond = 1'b0;
    case (ctrl_q)
      3'b001: cond = (rs1_q == rs2_q);
      3'b010: cond = (rs1_q != rs2_q);
      3'b011: cond = ($signed(rs1_q) <  $signed(rs2_q));
      3'b100: cond = ($signed(rs1_q) >= $signed(rs2_q));
      3'b101: cond = (rs1_q <  rs2_q);
      3'b110: cond = (rs1_q >= rs2_q);
      default: cond = 1'b0;
    endcase
    taken  = valid_q & (jal_q | jalr_q | cond);
    target = jalr_q ? ((rs1_q + imm_q) & ~XLEN'(1)) : (pc_q + imm_q);
    if (!valid_q) target = '0;

    bus.finish  = (state_q == ST_DONE);
    bus.busy    = (state_q != ST_IDLE);
    bus.cmp_res = taken;
    bus.PC_jump = target;
    bus.PC_wb   = valid_q ? (pc_q + XLEN'(4)) : '0;
`ifdef JUMP_PREDICT_EN
    bus.mispredict = (state_q == ST_DONE) &&
                     ((taken != pt_q) || (taken && (target != ptgt_q)));
`endif
  end

endmodule

// File: tb/tb_fu_jump_pipe.sv
// Scoreboard bench for fu_jump_pipe: four instances with LAT=1..4 share stimulus,
// only the selected one sees EN; expected results are queued at issue and checked on finish.
module tb_fu_jump_pipe;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0, flush = 1'b0, jal = 1'b0, jalr = 1'b0, pt = 1'b0;
  logic [2:0] ctrl = '0;
  logic [XLEN-1:0] rs1 = '0, rs2 = '0, imm = '0, pc = '0, ptgt = '0;
  int sel = 0;

  logic            fin [4];
  logic            bsy [4];
  logic            cres[4];
  logic            mis [4];
  logic [XLEN-1:0] pj  [4];
  logic [XLEN-1:0] pw  [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    fu_jump_pipe_if #(.XLEN(XLEN)) bus ();
    assign bus.EN       = en && (sel == g);
    assign bus.flush    = flush;
    assign bus.JAL      = jal;
    assign bus.JALR     = jalr;
    assign bus.cmp_ctrl = ctrl;
    assign bus.rs1_data = rs1;
    assign bus.rs2_data = rs2;
    assign bus.imm      = imm;
    assign bus.PC       = pc;
    assign fin[g]  = bus.finish;
    assign bsy[g]  = bus.busy;
    assign cres[g] = bus.cmp_res;
    assign pj[g]   = bus.PC_jump;
    assign pw[g]   = bus.PC_wb;
`ifdef JUMP_PREDICT_EN
    assign bus.pred_taken  = pt;
    assign bus.pred_target = ptgt;
    assign mis[g] = bus.mispredict;
`else
    assign mis[g] = 1'b0;
`endif
    fu_jump_pipe #(.XLEN(XLEN), .LAT(g + 1)) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
    );
  end

  typedef struct packed {
    logic [XLEN-1:0] jump;
    logic [XLEN-1:0] wb;
    logic            taken;
    logic            mis;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] c, input logic j, input logic jr,
                                 input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                 input logic [XLEN-1:0] im, input logic [XLEN-1:0] p,
                                 input logic t, input logic [XLEN-1:0] tg);
    exp_t e;
    logic c_ok;
    case (c)
      3'b001:  c_ok = (a == b);
      3'b010:  c_ok = (a != b);
      3'b011:  c_ok = ($signed(a) <  $signed(b));
      3'b100:  c_ok = ($signed(a) >= $signed(b));
      3'b101:  c_ok = (a < b);
      3'b110:  c_ok = (a >= b);
      default: c_ok = 1'b0;
    endcase
    e.taken = j | jr | c_ok;
    e.jump  = jr ? ((a + im) & 32'hFFFF_FFFE) : (p + im);
    e.wb    = p + 32'd4;
    e.mis   = (e.taken != t) || (e.taken && (e.jump != tg));
    return e;
  endfunction

  task automatic drive_op(input logic [2:0] c, input logic j, input logic jr,
                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic [XLEN-1:0] im, input logic [XLEN-1:0] p,
                          input logic t, input logic [XLEN-1:0] tg, input bit push);
    ctrl = c; jal = j; jalr = jr; rs1 = a; rs2 = b; imm = im; pc = p;
    pt = t; ptgt = tg; en = 1'b1;
    if (push) sb_q.push_back(model(c, j, jr, a, b, im, p, t, tg));
  endtask

  task automatic issue(input logic [2:0] c, input logic j, input logic jr,
                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [XLEN-1:0] im, input logic [XLEN-1:0] p,
                       input logic t, input logic [XLEN-1:0] tg, input bit push);
    drive_op(c, j, jr, a, b, im, p, t, tg, push);
    @(negedge clk);
    en = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && fin[sel]) begin
      if (sb_q.size() == 0) begin
        check("spurious_finish", 64'(fin[sel]), 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("pc_jump", 64'(pj[sel]), 64'(mon_e.jump));
        check("pc_wb",   64'(pw[sel]), 64'(mon_e.wb));
        check("cmp_res", 64'(cres[sel]), 64'(mon_e.taken));
`ifdef JUMP_PREDICT_EN
        check("mispredict", 64'(mis[sel]), 64'(mon_e.mis));
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] c;
    logic j, jr, t;
    logic [XLEN-1:0] a, b, im, p, tg;
    exp_t e;

    repeat (2) @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      check($sformatf("rst_busy%0d", s), 64'(bsy[s]), 64'd0);
      check($sformatf("rst_fin%0d", s),  64'(fin[s]), 64'd0);
      check($sformatf("rst_pcwb%0d", s), 64'(pw[s]),  64'd0);
      check($sformatf("rst_pcj%0d", s),  64'(pj[s]),  64'd0);
      check($sformatf("rst_cmp%0d", s),  64'(cres[s]), 64'd0);
      check($sformatf("rst_mis%0d", s),  64'(mis[s]), 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // LAT=1: BEQ taken, finish the next cycle only
    sel = 0;
    issue(3'b001, 1'b0, 1'b0, 32'd5, 32'd5, 32'h20, 32'h100, 1'b1, 32'h120, 1'b1);
    check("lat1_fin", 64'(fin[0]), 64'd1);
    check("lat1_pcj", 64'(pj[0]), 64'h120);
    @(negedge clk);
    check("lat1_fin_clr", 64'(fin[0]), 64'd0);

    // LAT=1: back-to-back random operations, one per cycle
    for (int i = 0; i < 24; i++) begin
      c  = 3'($urandom_range(0, 7));
      j  = ($urandom_range(0, 5) == 0);
      jr = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 3))
        0: a = 32'h8000_0000;
        1: a = 32'h7FFF_FFFF;
        default: a = $urandom;
      endcase
      b  = ($urandom_range(0, 2) == 0) ? a : $urandom;
      im = $urandom;
      p  = $urandom;
      t  = 1'($urandom_range(0, 1));
      e  = model(c, j, jr, a, b, im, p, t, 32'd0);
      tg = ($urandom_range(0, 1) == 0) ? e.jump : $urandom;
      drive_op(c, j, jr, a, b, im, p, t, tg, 1'b1);
      @(negedge clk);
    end
    en = 1'b0;
    repeat (2) @(negedge clk);

    // LAT=3: JALR, EN during RUN ignored
    sel = 2;
    issue(3'b000, 1'b0, 1'b1, 32'h1001, 32'd0, 32'h10, 32'h200, 1'b1, 32'h1010, 1'b1);
    check("lat3_c1_busy", 64'(bsy[2]), 64'd1);
    check("lat3_c1_fin",  64'(fin[2]), 64'd0);
    drive_op(3'b001, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h1234, 32'h5555, 32'h9000, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    check("lat3_c2_busy", 64'(bsy[2]), 64'd1);
    check("lat3_c2_fin",  64'(fin[2]), 64'd0);
    @(negedge clk);
    en = 1'b0;
    check("lat3_c3_fin",  64'(fin[2]), 64'd1);
    check("lat3_c3_busy", 64'(bsy[2]), 64'd1);
    @(negedge clk);
    check("lat3_c4_fin",  64'(fin[2]), 64'd0);
    check("lat3_c4_busy", 64'(bsy[2]), 64'd0);

    // LAT=2: BLT then BLTU issued in the DONE cycle
    sel = 1;
    issue(3'b011, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h300, 1'b1, 32'h340, 1'b1);
    check("lat2_c1_fin", 64'(fin[1]), 64'd0);
    @(negedge clk);
    check("lat2_c2_fin", 64'(fin[1]), 64'd1);
    issue(3'b101, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h300, 1'b0, 32'd0, 1'b1);
    check("lat2_c3_fin",  64'(fin[1]), 64'd0);
    check("lat2_c3_busy", 64'(bsy[1]), 64'd1);
    @(negedge clk);
    check("lat2_c4_fin", 64'(fin[1]), 64'd1);
    check("lat2_c4_cmp", 64'(cres[1]), 64'd0);
    @(negedge clk);
    check("lat2_c5_busy", 64'(bsy[1]), 64'd0);

    // LAT=4: flush with simultaneous EN
    sel = 3;
    issue(3'b010, 1'b0, 1'b0, 32'd1, 32'd2, 32'h8, 32'h400, 1'b0, 32'd0, 1'b0);
    check("lat4_c1_busy", 64'(bsy[3]), 64'd1);
    @(negedge clk);
    flush = 1'b1;
    drive_op(3'b001, 1'b1, 1'b0, 32'd3, 32'd3, 32'h4, 32'h500, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    flush = 1'b0;
    en = 1'b0;
    check("flush_busy", 64'(bsy[3]), 64'd0);
    check("flush_fin",  64'(fin[3]), 64'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("flush_no_fin", 64'(fin[3]), 64'd0);
    end

    // LAT=4: reset mid-operation
    issue(3'b001, 1'b1, 1'b0, 32'd9, 32'd9, 32'h44, 32'h600, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(bsy[3]), 64'd0);
    check("arst_fin",  64'(fin[3]), 64'd0);
    check("arst_pcwb", 64'(pw[3]),  64'd0);
    check("arst_pcj",  64'(pj[3]),  64'd0);
    check("arst_cmp",  64'(cres[3]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("arst_no_fin", 64'(fin[3]), 64'd0);
    end

`ifdef JUMP_PREDICT_EN
    sel = 0;
    issue(3'b010, 1'b0, 1'b0, 32'd7, 32'd7, 32'h10, 32'h700, 1'b1, 32'h710, 1'b1);
    check("pred_mis1", 64'(mis[0]), 64'd1);
    @(negedge clk);
    issue(3'b010, 1'b0, 1'b0, 32'd7, 32'd7, 32'h10, 32'h700, 1'b0, 32'h710, 1'b1);
    check("pred_mis0", 64'(mis[0]), 64'd0);
    @(negedge clk);
`endif

    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
